// File: rtl/klavye_kodlayici_if.sv
// klavye_kodlayici_if: character-in / scan-code-out handshake bundle
// Ports (signals):
//   giris_gecerli, giris[7:0], giris_hazir : character valid/ready stream
//   cikis_gecerli, cikis[7:0], cikis_hazir : scan-code byte valid/ready stream
//   hata                                   : unsupported-character pulse
// master drives characters and consumes bytes; slave is the encoder.
interface klavye_kodlayici_if;
  logic       giris_gecerli;
  logic [7:0] giris;
  logic       giris_hazir;
  logic       cikis_gecerli;
  logic [7:0] cikis;
  logic       cikis_hazir;
  logic       hata;
  modport master (
    output giris_gecerli, giris, cikis_hazir,
    input  giris_hazir, cikis_gecerli, cikis, hata
  );
  modport slave (
    input  giris_gecerli, giris, cikis_hazir,
    output giris_hazir, cikis_gecerli, cikis, hata
  );
endinterface

// File: rtl/klavye_kodlayici.sv
// klavye_kodlayici: character code to PS/2 Set-2 scan-code byte stream encoder
// Ports:
//   clk      : system clock, all logic on posedge
//   rst_n    : synchronous active-low reset
//   io_kanal : klavye_kodlayici_if.slave (character in, scan-code bytes out, hata)
// Parameter MOLA: idle cycles inserted after every transferred output byte.
// Macro BIRAKMA_KODU_EN: defined emits make+break (F0) codes; undefined is make-only.
module klavye_kodlayici #(
  parameter int unsigned MOLA = 0
) (
  input logic               clk,
  input logic               rst_n,
  klavye_kodlayici_if.slave io_kanal
);
  localparam int SW = MOLA > 1 ? $clog2(MOLA) : 1;
  typedef enum logic [2:0] {
    BOS,
    SHIFT_BAS,
    TUS_BAS,
`ifdef BIRAKMA_KODU_EN
    F0_1,
    TUS_BIRAK,
    F0_2,
    SHIFT_BIRAK,
`endif
    BEKLE
  } durum_t;
  function automatic logic [7:0] harf_kodu(input logic [4:0] i);
    case (i)
      5'd0:  return 8'h1C;
      5'd1:  return 8'h32;
      5'd2:  return 8'h21;
      5'd3:  return 8'h23;
      5'd4:  return 8'h24;
      5'd5:  return 8'h2B;
      5'd6:  return 8'h34;
      5'd7:  return 8'h33;
      5'd8:  return 8'h43;
      5'd9:  return 8'h3B;
      5'd10: return 8'h42;
      5'd11: return 8'h4B;
      5'd12: return 8'h3A;
      5'd13: return 8'h31;
      5'd14: return 8'h44;
      5'd15: return 8'h4D;
      5'd16: return 8'h15;
      5'd17: return 8'h2D;
      5'd18: return 8'h1B;
      5'd19: return 8'h2C;
      5'd20: return 8'h3C;
      5'd21: return 8'h2A;
      5'd22: return 8'h1D;
      5'd23: return 8'h22;
      5'd24: return 8'h35;
      5'd25: return 8'h1A;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] rakam_kodu(input logic [3:0] d);
    case (d)
      4'd0: return 8'h45;
      4'd1: return 8'h16;
      4'd2: return 8'h1E;
      4'd3: return 8'h26;
      4'd4: return 8'h25;
      4'd5: return 8'h2E;
      4'd6: return 8'h36;
      4'd7: return 8'h3D;
      4'd8: return 8'h3E;
      4'd9: return 8'h46;
      default: return 8'h00;
    endcase
  endfunction
  function automatic durum_t sonraki_durum(input durum_t s, input logic sh);
`ifdef BIRAKMA_KODU_EN
    return s == SHIFT_BAS ? TUS_BAS :
           s == TUS_BAS ? F0_1 :
           s == F0_1 ? TUS_BIRAK :
           s == TUS_BIRAK && sh ? F0_2 :
           s == F0_2 ? SHIFT_BIRAK : BOS;
`else
    return s == SHIFT_BAS && sh ? TUS_BAS : BOS;
`endif
  endfunction
  function automatic logic [7:0] bayt(input durum_t s, input logic [7:0] kod);
`ifdef BIRAKMA_KODU_EN
    return s == SHIFT_BAS || s == SHIFT_BIRAK ? 8'h12 :
           s == F0_1 || s == F0_2 ? 8'hF0 : kod;
`else
    return s == SHIFT_BAS ? 8'h12 : kod;
`endif
  endfunction
  // {supported, needs shift wrap, make code}
  logic [9:0] w_esle;
  always_comb begin
    w_esle = '0;
    if (io_kanal.giris >= 8'h61 && io_kanal.giris <= 8'h7A)
      w_esle = {2'b10, harf_kodu(5'(io_kanal.giris - 8'h61))};
    else if (io_kanal.giris >= 8'h41 && io_kanal.giris <= 8'h5A)
      w_esle = {2'b11, harf_kodu(5'(io_kanal.giris - 8'h41))};
    else if (io_kanal.giris >= 8'h30 && io_kanal.giris <= 8'h39)
      w_esle = {2'b10, rakam_kodu(4'(io_kanal.giris - 8'h30))};
    else
      case (io_kanal.giris)
        8'h21: w_esle = {2'b11, rakam_kodu(4'd1)};
        8'h40: w_esle = {2'b11, rakam_kodu(4'd2)};
        8'h23: w_esle = {2'b11, rakam_kodu(4'd3)};
        8'h24: w_esle = {2'b11, rakam_kodu(4'd4)};
        8'h25: w_esle = {2'b11, rakam_kodu(4'd5)};
        8'h5E: w_esle = {2'b11, rakam_kodu(4'd6)};
        8'h26: w_esle = {2'b11, rakam_kodu(4'd7)};
        8'h2A: w_esle = {2'b11, rakam_kodu(4'd8)};
        8'h28: w_esle = {2'b11, rakam_kodu(4'd9)};
        8'h29: w_esle = {2'b11, rakam_kodu(4'd0)};
        8'h20: w_esle = {2'b10, 8'h29};
        8'h09: w_esle = {2'b10, 8'h0D};
        8'h08: w_esle = {2'b10, 8'h66};
        8'h1B: w_esle = {2'b10, 8'h76};
        default: w_esle = '0;
      endcase
  end
  durum_t r_durum, r_sonraki, w_hedef;
  logic r_shift, r_giris_hazir, r_cikis_gecerli, r_hata;
  logic [7:0] r_kod, r_cikis;
  logic [SW-1:0] r_sayac;
  // BEKLE resumes the state parked in r_sonraki; otherwise step along the sequence
  assign w_hedef = r_durum == BEKLE ? r_sonraki : sonraki_durum(r_durum, r_shift);
  assign io_kanal.giris_hazir   = r_giris_hazir;
  assign io_kanal.cikis_gecerli = r_cikis_gecerli;
  assign io_kanal.cikis         = r_cikis;
  assign io_kanal.hata          = r_hata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_durum         <= BOS;
      r_sonraki       <= BOS;
      r_shift         <= 1'b0;
      r_kod           <= 8'h00;
      r_sayac         <= '0;
      r_giris_hazir   <= 1'b1;
      r_cikis_gecerli <= 1'b0;
      r_cikis         <= 8'h00;
      r_hata          <= 1'b0;
    end else begin
      r_hata <= 1'b0;
      if (r_durum == BOS && io_kanal.giris_gecerli && w_esle[9]) begin
        r_shift         <= w_esle[8];
        r_kod           <= w_esle[7:0];
        r_durum         <= w_esle[8] ? SHIFT_BAS : TUS_BAS;
        r_cikis         <= w_esle[8] ? 8'h12 : w_esle[7:0];
        r_cikis_gecerli <= 1'b1;
        r_giris_hazir   <= 1'b0;
      end else if (r_durum == BOS && io_kanal.giris_gecerli) begin
        r_hata <= 1'b1;
      end else if (r_durum == BEKLE && r_sayac != '0) begin
        r_sayac <= r_sayac - 1'b1;
      end else if (r_durum == BEKLE || (r_cikis_gecerli && io_kanal.cikis_hazir && MOLA == 0)) begin
        r_durum         <= w_hedef;
        r_cikis_gecerli <= w_hedef != BOS;
        r_giris_hazir   <= w_hedef == BOS;
        if (w_hedef != BOS) r_cikis <= bayt(w_hedef, r_kod);
      end else if (r_cikis_gecerli && io_kanal.cikis_hazir) begin
        r_durum         <= BEKLE;
        r_sonraki       <= w_hedef;
        r_sayac         <= SW'(MOLA - 1);
        r_cikis_gecerli <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_klavye_kodlayici.sv
// tb_klavye_kodlayici: vector, random and corner-case checks for klavye_kodlayici
module tb_klavye_kodlayici;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  klavye_kodlayici_if k0();
  klavye_kodlayici_if k2();
  klavye_kodlayici #(.MOLA(0)) u0 (.clk(clk), .rst_n(rst_n), .io_kanal(k0));
  klavye_kodlayici #(.MOLA(2)) u2 (.clk(clk), .rst_n(rst_n), .io_kanal(k2));
  typedef struct packed {
    logic [7:0] ch;
    logic       sh;
    logic [7:0] kod;
    logic       err;
  } vektor_t;
  int hata_say = 0;
  int kontrol = 0;
  logic [8:0] harita [logic [7:0]];
  logic [7:0] beklenen[$];
  logic [7:0] alinan[$];
  task automatic kontrol_et(input string ad, input logic [31:0] g, input logic [31:0] b);
    kontrol++;
    if (g !== b) begin
      hata_say++;
      $display("FAIL %s: got %0h expected %0h", ad, g, b);
    end
  endtask
  task automatic zaman_asimi(input string ad);
    kontrol++;
    hata_say++;
    $display("FAIL %s: timed out waiting for DUT", ad);
  endtask
  // expected byte stream from the keyboard rules: shift wrap around make (and break) codes
  function automatic void genislet(input logic err, input logic sh, input logic [7:0] kod);
    beklenen.delete();
    if (!err) begin
      if (sh) beklenen.push_back(8'h12);
      beklenen.push_back(kod);
`ifdef BIRAKMA_KODU_EN
      beklenen.push_back(8'hF0);
      beklenen.push_back(kod);
      if (sh) begin
        beklenen.push_back(8'hF0);
        beklenen.push_back(8'h12);
      end
`endif
    end
  endfunction
  task automatic dizi_kontrol(input string ad);
    bit ok;
    string sg, sb;
    ok = alinan.size() == beklenen.size();
    for (int i = 0; ok && i < alinan.size(); i++) ok = alinan[i] == beklenen[i];
    kontrol++;
    if (!ok) begin
      hata_say++;
      sg = "";
      sb = "";
      for (int i = 0; i < alinan.size() && i < 20; i++) sg = {sg, $sformatf("%02h ", alinan[i])};
      for (int i = 0; i < beklenen.size(); i++) sb = {sb, $sformatf("%02h ", beklenen[i])};
      $display("FAIL %s: got [%s] expected [%s]", ad, sg, sb);
    end
  endtask
  // mod 0: always ready, 1: ready low for first 4 cycles, 2: random ready
  task automatic gonder(input logic [7:0] ch, input int mod, output int dongu, output int hata_n, output int kayma);
    int bek;
    logic hz, tut, bitti;
    logic [7:0] tut_bayt;
    alinan.delete();
    dongu = 0;
    hata_n = 0;
    kayma = 0;
    bek = 0;
    tut = 1'b0;
    tut_bayt = 8'h00;
    bitti = 1'b0;
    while (!k0.giris_hazir && bek < 200) begin
      @(negedge clk);
      bek++;
    end
    if (!k0.giris_hazir) zaman_asimi("giris_hazir");
    k0.giris_gecerli = 1'b1;
    k0.giris = ch;
    @(negedge clk);
    k0.giris_gecerli = 1'b0;
    k0.giris = 8'($urandom);
    for (int c = 0; c < 200 && !bitti; c++) begin
      if (k0.hata) hata_n++;
      if (tut && (!k0.cikis_gecerli || k0.cikis !== tut_bayt)) kayma++;
      if (k0.giris_hazir) bitti = 1'b1;
      else begin
        hz = mod == 0 ? 1'b1 : mod == 1 ? (c >= 4) : 1'($urandom_range(0, 1));
        k0.cikis_hazir = hz;
        if (k0.cikis_gecerli && hz) alinan.push_back(k0.cikis);
        tut = k0.cikis_gecerli && !hz;
        tut_bayt = k0.cikis;
        dongu++;
        @(negedge clk);
      end
    end
    if (!bitti) zaman_asimi("dizi sonu");
  endtask
  initial begin
    static string hrf = "qwertyuiopasdfghjklzxcvbnm";
    static string rkm = "1234567890";
    static string sem = "!@#$%^&*()";
    static string tuslar = "qwertyuiopasdfghjklzxcvbnmQWERTYUIOPASDFGHJKLZXCVBNM1234567890!@#$%^&*() ";
    logic [7:0] hkod [26] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D,
                              8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B,
                              8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A};
    logic [7:0] rkod [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    vektor_t tablo [19] = '{
      '{8'h61, 1'b0, 8'h1C, 1'b0}, '{8'h41, 1'b1, 8'h1C, 1'b0}, '{8'h21, 1'b1, 8'h16, 1'b0},
      '{8'h35, 1'b0, 8'h2E, 1'b0}, '{8'h7F, 1'b0, 8'h00, 1'b1}, '{8'h62, 1'b0, 8'h32, 1'b0},
      '{8'h5A, 1'b1, 8'h1A, 1'b0}, '{8'h71, 1'b0, 8'h15, 1'b0}, '{8'h30, 1'b0, 8'h45, 1'b0},
      '{8'h29, 1'b1, 8'h45, 1'b0}, '{8'h5E, 1'b1, 8'h36, 1'b0}, '{8'h20, 1'b0, 8'h29, 1'b0},
      '{8'h09, 1'b0, 8'h0D, 1'b0}, '{8'h08, 1'b0, 8'h66, 1'b0}, '{8'h1B, 1'b0, 8'h76, 1'b0},
      '{8'h6D, 1'b0, 8'h3A, 1'b0}, '{8'h40, 1'b1, 8'h1E, 1'b0}, '{8'h7B, 1'b0, 8'h00, 1'b1},
      '{8'h00, 1'b0, 8'h00, 1'b1}};
    int dongu, hn, ky;
    logic [7:0] ch;
    for (int i = 0; i < 26; i++) begin
      harita[8'(hrf[i])] = {1'b0, hkod[i]};
      harita[8'(hrf[i] - 8'd32)] = {1'b1, hkod[i]};
    end
    for (int i = 0; i < 10; i++) begin
      harita[8'(rkm[i])] = {1'b0, rkod[i]};
      harita[8'(sem[i])] = {1'b1, rkod[i]};
    end
    harita[8'h20] = {1'b0, 8'h29};
    harita[8'h09] = {1'b0, 8'h0D};
    harita[8'h08] = {1'b0, 8'h66};
    harita[8'h1B] = {1'b0, 8'h76};
    k0.giris_gecerli = 1'b0;
    k0.giris = 8'h00;
    k0.cikis_hazir = 1'b1;
    k2.giris_gecerli = 1'b0;
    k2.giris = 8'h00;
    k2.cikis_hazir = 1'b1;
    repeat (3) @(negedge clk);
    kontrol_et("reset k0", {k0.giris_hazir, k0.cikis_gecerli, k0.cikis, k0.hata}, {1'b1, 1'b0, 8'h00, 1'b0});
    kontrol_et("reset k2", {k2.giris_hazir, k2.cikis_gecerli, k2.cikis, k2.hata}, {1'b1, 1'b0, 8'h00, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tablo[i]) begin
      genislet(tablo[i].err, tablo[i].sh, tablo[i].kod);
      gonder(tablo[i].ch, 0, dongu, hn, ky);
      dizi_kontrol($sformatf("tablo %02h bytes", tablo[i].ch));
      kontrol_et($sformatf("tablo %02h hata", tablo[i].ch), hn, 32'(tablo[i].err));
      kontrol_et($sformatf("tablo %02h cycles", tablo[i].ch), dongu, beklenen.size());
      if (tablo[i].err) begin
        @(negedge clk);
        kontrol_et("hata one cycle", {k0.hata, k0.cikis_gecerli, k0.giris_hazir}, 3'b001);
      end
    end
    genislet(1'b0, 1'b0, 8'h2E);
    kontrol_et("stall first byte", {k0.giris_hazir, 8'h00}, {1'b1, 8'h00});
    gonder(8'h35, 1, dongu, hn, ky);
    dizi_kontrol("stall bytes");
    kontrol_et("stall stable", ky, 0);
    kontrol_et("stall cycles", dongu, beklenen.size() + 4);
    for (int n = 0; n < 60; n++) begin
      ch = $urandom_range(0, 4) == 0 ? 8'($urandom) : 8'(tuslar[$urandom_range(0, tuslar.len() - 1)]);
      if (harita.exists(ch)) genislet(1'b0, harita[ch][8], harita[ch][7:0]);
      else genislet(1'b1, 1'b0, 8'h00);
      gonder(ch, 2, dongu, hn, ky);
      dizi_kontrol($sformatf("random %02h bytes", ch));
      kontrol_et($sformatf("random %02h hata", ch), hn, 32'(!harita.exists(ch)));
      kontrol_et($sformatf("random %02h stable", ch), ky, 0);
    end
    genislet(1'b0, 1'b0, 8'h32);
    k2.giris_gecerli = 1'b1;
    k2.giris = 8'h62;
    @(negedge clk);
    k2.giris_gecerli = 1'b0;
    for (int i = 0; i < beklenen.size(); i++) begin
      kontrol_et($sformatf("mola byte %0d", i), {k2.cikis_gecerli, k2.cikis, k2.giris_hazir}, {1'b1, beklenen[i], 1'b0});
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        kontrol_et($sformatf("mola gap %0d.%0d", i, g), {k2.cikis_gecerli, k2.giris_hazir}, 2'b00);
      end
      @(negedge clk);
    end
    kontrol_et("mola ready", k2.giris_hazir, 1'b1);
    genislet(1'b0, 1'b1, 8'h1A);
    while (!k0.giris_hazir) @(negedge clk);
    k0.cikis_hazir = 1'b1;
    k0.giris_gecerli = 1'b1;
    k0.giris = 8'h5A;
    @(negedge clk);
    k0.giris_gecerli = 1'b0;
    kontrol_et("reset seq byte0", {k0.cikis_gecerli, k0.cikis}, {1'b1, beklenen[0]});
    @(negedge clk);
    kontrol_et("reset seq byte1", {k0.cikis_gecerli, k0.cikis}, {1'b1, beklenen[1]});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    kontrol_et("reset mid seq", {k0.giris_hazir, k0.cikis_gecerli, k0.cikis, k0.hata}, {1'b1, 1'b0, 8'h00, 1'b0});
    rst_n = 1'b1;
    genislet(1'b0, 1'b0, 8'h1A);
    gonder(8'h7A, 0, dongu, hn, ky);
    dizi_kontrol("after reset z");
    kontrol_et("after reset cycles", dongu, beklenen.size());
    $display("Result: errors=%0d of %0d checks", hata_say, kontrol);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
